// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode values and FSM state encoding.
package alu_pkg;

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul.sv
// Iterative shift-add multiplier producing the low WIDTH bits of a*b.
// One partial-product step is taken per clock for WIDTH clocks after start.
// The product output already includes the step being taken this cycle, so
// the parent can capture the final value on the same edge as the last step,
// which is exactly the cycle in which done is high.
module alu_mul #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] STEPS = CW'(WIDTH);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic [CW-1:0]    count;

  assign product = acc + (multiplier[0] ? multiplicand : '0);
  assign done    = (count == CW'(1));

  // Latch operands on start, then shift multiplicand left / multiplier right
  // each cycle, accumulating while the counter runs down to zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc          <= '0;
      multiplicand <= '0;
      multiplier   <= '0;
      count        <= '0;
    end else if (start) begin
      acc          <= '0;
      multiplicand <= a;
      multiplier   <= b;
      count        <= STEPS;
    end else if (count != '0) begin
      acc          <= product;
      multiplicand <= multiplicand << 1;
      multiplier   <= multiplier >> 1;
      count        <= count - CW'(1);
    end
  end

endmodule

// File: rtl/param_seq_alu.sv
// Sequential ALU with a valid/ready handshake on both sides.
// Single-cycle ops register their result on the accept edge; MUL runs the
// iterative multiplier for WIDTH cycles. The result is held in DONE until the
// consumer takes it, and IN_READY is only high in IDLE, which leaves a
// one-cycle bubble between consuming a result and accepting the next op.
module param_seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic [2:0]       SELECT,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             CARRY,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH:0]   aluOut;
  logic [WIDTH:0]   addSum;
  logic [WIDTH:0]   subDiff;
  logic [SHW-1:0]   shiftAmt;
  logic             accept;
  logic             mulStart;
  logic             mulDone;
  logic [WIDTH-1:0] mulProduct;

  assign IN_READY = (state == IDLE);
  assign accept   = IN_VALID && IN_READY;
  assign mulStart = accept && (SELECT == OP_MUL);
  assign shiftAmt = DATA2[SHW-1:0];
  assign addSum   = {1'b0, DATA1} + {1'b0, DATA2};
  assign subDiff  = {1'b0, DATA1} + {1'b0, ~DATA2} + (WIDTH+1)'(1);

  // Single-cycle datapath: bit WIDTH carries carry-out / not-borrow and is 0 for logic ops.
  always_comb begin
    aluOut = '0;
    case (SELECT)
      OP_FWD:  aluOut = {1'b0, DATA2};
      OP_ADD:  aluOut = addSum;
      OP_AND:  aluOut = {1'b0, DATA1 & DATA2};
      OP_OR:   aluOut = {1'b0, DATA1 | DATA2};
      OP_SUB:  aluOut = subDiff;
      OP_SLL:  aluOut = {1'b0, DATA1 << shiftAmt};
      OP_SRL:  aluOut = {1'b0, DATA1 >> shiftAmt};
      default: aluOut = '0;
    endcase
  end

  alu_mul #(.WIDTH(WIDTH)) uMul (
    .clock   (CLK),
    .reset   (RESET),
    .start   (mulStart),
    .a       (DATA1),
    .b       (DATA2),
    .done    (mulDone),
    .product (mulProduct)
  );

  // Control FSM and registered outputs; inputs are only looked at in IDLE.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      RESULT    <= '0;
      ZERO      <= 1'b0;
      CARRY     <= 1'b0;
      OUT_VALID <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (IN_VALID) begin
            if (SELECT == OP_MUL) begin
              state <= MUL;
            end else begin
              RESULT    <= aluOut[WIDTH-1:0];
              ZERO      <= (aluOut[WIDTH-1:0] == '0);
              CARRY     <= aluOut[WIDTH];
              OUT_VALID <= 1'b1;
              state     <= DONE;
            end
          end
        end
        MUL: begin
          if (mulDone) begin
            RESULT    <= mulProduct;
            ZERO      <= (mulProduct == '0);
            CARRY     <= 1'b0;
            OUT_VALID <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          OUT_VALID <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_seq_alu.sv
// Self-checking bench for param_seq_alu: a table of single operations on an
// 8-bit instance, then hand-written sequences for stalling, the accept bubble,
// reset in the middle of a multiply, and a 16-bit multiply.
module tb_param_seq_alu;
  import alu_pkg::*;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] expRes;
    logic       expZero;
    logic       expCarry;
    int         expLat;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;

  logic [7:0] a8, b8, res8;
  logic [2:0] sel8;
  logic       inValid8, inReady8, zero8, carry8, outValid8, outReady8;

  logic [15:0] a16, b16, res16;
  logic [2:0]  sel16;
  logic        inValid16, inReady16, zero16, carry16, outValid16, outReady16;

  int checks = 0;
  int failures = 0;

  vec_t vecs[14];

  always #5 clk = ~clk;

  param_seq_alu #(.WIDTH(8)) dut8 (
    .CLK(clk), .RESET(reset), .DATA1(a8), .DATA2(b8), .SELECT(sel8),
    .IN_VALID(inValid8), .IN_READY(inReady8), .RESULT(res8), .ZERO(zero8),
    .CARRY(carry8), .OUT_VALID(outValid8), .OUT_READY(outReady8)
  );

  param_seq_alu #(.WIDTH(16)) dut16 (
    .CLK(clk), .RESET(reset), .DATA1(a16), .DATA2(b16), .SELECT(sel16),
    .IN_VALID(inValid16), .IN_READY(inReady16), .RESULT(res16), .ZERO(zero16),
    .CARRY(carry16), .OUT_VALID(outValid16), .OUT_READY(outReady16)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Present one op on the 8-bit DUT, then count cycles until OUT_VALID.
  // Operands are scrambled after the accept edge so a multiply that fails
  // to latch its operands shows up as a wrong product.
  task automatic applyStimulus(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                               output int lat, output bit readyLow);
    @(negedge clk);
    sel8 = sel; a8 = a; b8 = b; inValid8 = 1'b1;
    @(posedge clk); #1;
    inValid8 = 1'b0; a8 = ~a; b8 = b ^ 8'h5A;
    lat = 1;
    readyLow = 1'b1;
    while (!outValid8 && lat < 40) begin
      if (inReady8) readyLow = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Take the pending result and confirm the block drops back to IDLE.
  task automatic consume8(input string name);
    @(negedge clk);
    outReady8 = 1'b1;
    @(posedge clk); #1;
    outReady8 = 1'b0;
    checkOutput({name, "_consumed_valid"}, 32'(outValid8), 32'd0);
    checkOutput({name, "_consumed_ready"}, 32'(inReady8), 32'd1);
  endtask

  initial begin
    int lat;
    bit readyLow;
    bit sawValid;

    vecs[0]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1};
    vecs[1]  = '{OP_SUB, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1};
    vecs[2]  = '{OP_SLL, 8'h81, 8'h09, 8'h02, 1'b0, 1'b0, 1};
    vecs[3]  = '{OP_FWD, 8'h12, 8'hA5, 8'hA5, 1'b0, 1'b0, 1};
    vecs[4]  = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1};
    vecs[5]  = '{OP_OR,  8'h0F, 8'h30, 8'h3F, 1'b0, 1'b0, 1};
    vecs[6]  = '{OP_SUB, 8'h07, 8'h05, 8'h02, 1'b0, 1'b1, 1};
    vecs[7]  = '{OP_SRL, 8'h80, 8'h07, 8'h01, 1'b0, 1'b0, 1};
    vecs[8]  = '{OP_ADD, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1};
    vecs[9]  = '{OP_SUB, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1};
    vecs[10] = '{OP_MUL, 8'h0C, 8'h0B, 8'h84, 1'b0, 1'b0, 9};
    vecs[11] = '{OP_MUL, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b0, 9};
    vecs[12] = '{OP_SLL, 8'h01, 8'h0F, 8'h80, 1'b0, 1'b0, 1};
    vecs[13] = '{OP_AND, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 1};

    reset = 1'b1;
    a8 = '0; b8 = '0; sel8 = '0; inValid8 = 1'b0; outReady8 = 1'b0;
    a16 = '0; b16 = '0; sel16 = '0; inValid16 = 1'b0; outReady16 = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_result", 32'(res8), 32'd0);
    checkOutput("reset_zero", 32'(zero8), 32'd0);
    checkOutput("reset_carry", 32'(carry8), 32'd0);
    checkOutput("reset_valid", 32'(outValid8), 32'd0);
    checkOutput("reset_result16", 32'(res16), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("ready_after_reset", 32'(inReady8), 32'd1);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].sel, vecs[i].a, vecs[i].b, lat, readyLow);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].expLat));
      checkOutput($sformatf("vec%0d_result", i), 32'(res8), 32'(vecs[i].expRes));
      checkOutput($sformatf("vec%0d_zero", i), 32'(zero8), 32'(vecs[i].expZero));
      checkOutput($sformatf("vec%0d_carry", i), 32'(carry8), 32'(vecs[i].expCarry));
      checkOutput($sformatf("vec%0d_ready_low", i), 32'(readyLow), 32'd1);
      consume8($sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d_result_held_idle", i), 32'(res8), 32'(vecs[i].expRes));
    end

    // Stall in DONE for 5 cycles while a new ADD is offered; it must be ignored.
    applyStimulus(OP_MUL, 8'h0C, 8'h0B, lat, readyLow);
    checkOutput("stall_mul_latency", 32'(lat), 32'd9);
    @(negedge clk);
    sel8 = OP_ADD; a8 = 8'h01; b8 = 8'h01; inValid8 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("stall%0d_valid", c), 32'(outValid8), 32'd1);
      checkOutput($sformatf("stall%0d_result", c), 32'(res8), 32'h84);
      checkOutput($sformatf("stall%0d_ready", c), 32'(inReady8), 32'd0);
    end
    // Consume with IN_VALID still high: no accept on the consume edge.
    @(negedge clk);
    outReady8 = 1'b1;
    @(posedge clk); #1;
    outReady8 = 1'b0;
    checkOutput("bubble_valid", 32'(outValid8), 32'd0);
    checkOutput("bubble_result", 32'(res8), 32'h84);
    checkOutput("bubble_ready", 32'(inReady8), 32'd1);
    @(posedge clk); #1;
    inValid8 = 1'b0;
    checkOutput("after_bubble_valid", 32'(outValid8), 32'd1);
    checkOutput("after_bubble_result", 32'(res8), 32'h02);
    consume8("after_bubble");

    // Reset asserted mid-cycle during the fourth cycle of a multiply.
    @(negedge clk);
    sel8 = OP_MUL; a8 = 8'h0C; b8 = 8'h0B; inValid8 = 1'b1;
    @(posedge clk); #1;
    inValid8 = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("midmul_reset_result", 32'(res8), 32'd0);
    checkOutput("midmul_reset_valid", 32'(outValid8), 32'd0);
    checkOutput("midmul_reset_zero", 32'(zero8), 32'd0);
    checkOutput("midmul_reset_ready", 32'(inReady8), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    sawValid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (outValid8) sawValid = 1'b1;
    end
    checkOutput("midmul_no_valid", 32'(sawValid), 32'd0);
    applyStimulus(OP_ADD, 8'h02, 8'h03, lat, readyLow);
    checkOutput("post_reset_add_latency", 32'(lat), 32'd1);
    checkOutput("post_reset_add_result", 32'(res8), 32'h05);
    consume8("post_reset_add");

    // 16-bit multiply whose product overflows to exactly zero.
    @(negedge clk);
    sel16 = OP_MUL; a16 = 16'h0100; b16 = 16'h0100; inValid16 = 1'b1;
    @(posedge clk); #1;
    inValid16 = 1'b0; a16 = 16'h1234; b16 = 16'h0003;
    lat = 1;
    readyLow = 1'b1;
    while (!outValid16 && lat < 60) begin
      if (inReady16) readyLow = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("mul16_latency", 32'(lat), 32'd17);
    checkOutput("mul16_result", 32'(res16), 32'd0);
    checkOutput("mul16_zero", 32'(zero16), 32'd1);
    checkOutput("mul16_carry", 32'(carry16), 32'd0);
    checkOutput("mul16_ready_low", 32'(readyLow), 32'd1);
    @(negedge clk);
    outReady16 = 1'b1;
    @(posedge clk); #1;
    outReady16 = 1'b0;
    checkOutput("mul16_consumed_valid", 32'(outValid16), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_seq_alu.md
PARAM_SEQ_ALU -- requirements
Module: param_seq_alu

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/result width in bits (legal values 4..32).
REQ-002 SHALL have port: CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port: RESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: DATA1  input  WIDTH  operand A.
REQ-005 SHALL have port: DATA2  input  WIDTH  operand B.
REQ-006 SHALL have port: SELECT  input  3  opcode.
REQ-007 SHALL have port: IN_VALID  input  1  operands and opcode valid.
REQ-008 SHALL have port: IN_READY  output  1  block can accept an operation.
REQ-009 SHALL have port: RESULT  output  WIDTH  registered result.
REQ-010 SHALL have port: ZERO  output  1  RESULT == 0.
REQ-011 SHALL have port: CARRY  output  1  carry-out (ADD) or not-borrow (SUB); 0 for other ops.
REQ-012 SHALL have port: OUT_VALID  output  1  RESULT/flags valid.
REQ-013 SHALL have port: OUT_READY  input  1  consumer accepts result.

Function
REQ-014 SHALL decode SELECT: 000 FORWARD (DATA2), 001 ADD, 010 AND, 011 OR, 100 SUB (DATA1-DATA2), 101 SLL, 110 SRL, 111 MUL (low WIDTH bits of product).
REQ-015 SHALL take the shift amount from DATA2[$clog2(WIDTH)-1:0]; upper DATA2 bits ignored.
REQ-016 SHALL compute ADD/SUB in WIDTH+1 bits; RESULT is the low WIDTH bits, CARRY bit WIDTH, wrapping modulo 2^WIDTH.
REQ-017 SHALL implement states IDLE, MUL, DONE.
REQ-018 SHALL accept an operation when IN_VALID && IN_READY at a rising edge; IN_READY = 1 only in IDLE.
REQ-019 SHALL, for opcodes 000-110, register RESULT/flags at the accept edge and enter DONE (OUT_VALID high the following cycle, latency 1).
REQ-020 SHALL, for MUL, latch operands, enter MUL, perform one shift-add step per cycle for WIDTH cycles, then enter DONE (latency WIDTH+1).
REQ-021 SHALL hold RESULT, ZERO, CARRY and OUT_VALID stable in DONE until OUT_READY is sampled high, then return to IDLE.
REQ-022 SHALL ignore DATA1, DATA2, SELECT and IN_VALID while in MUL or DONE.
REQ-023 SHALL not accept a new operation in the same cycle a result is consumed (one-cycle IDLE bubble between operations).
REQ-024 SHALL keep RESULT at its last value in IDLE; OUT_VALID low in IDLE and MUL.

Reset
REQ-025 SHALL, on RESET high, immediately force state IDLE, RESULT 0, ZERO 0, CARRY 0, OUT_VALID 0, multiplier counter 0, regardless of clock.
REQ-026 SHALL abort any in-progress MUL or pending DONE result on reset without producing OUT_VALID.
REQ-027 SHALL drive IN_READY 1 on the first rising edge after RESET deasserts.

Structure
REQ-028 SHALL place opcode constants and the state encoding in shared package alu_pkg.
REQ-029 SHALL implement the iterative multiplier as sub-module alu_mul (start, operands, done, product) instantiated once.
REQ-030 SHALL contain no combinational path from inputs to RESULT, flags or OUT_VALID.

Verification (WIDTH=8 unless stated)
REQ-031 SHALL cover ADD 0xFF+0x01 -> RESULT 0x00, ZERO 1, CARRY 1, OUT_VALID one cycle after accept.
REQ-032 SHALL cover SUB 0x05-0x07 -> RESULT 0xFE, CARRY 0; SLL 0x81 by DATA2=0x09 -> RESULT 0x02 (shift 1).
REQ-033 SHALL cover MUL 0x0C*0x0B -> RESULT 0x84, OUT_VALID exactly 9 cycles after accept, IN_READY low throughout.
REQ-034 SHALL cover OUT_READY held low 5 cycles in DONE -> RESULT/OUT_VALID stable; IN_VALID with new operands ignored.
REQ-035 SHALL cover RESET asserted mid-MUL (cycle 4) -> outputs 0 asynchronously, no OUT_VALID, next ADD 0x02+0x03 -> 0x05.
REQ-036 SHALL cover WIDTH=16 MUL 0x0100*0x0100 -> RESULT 0x0000, ZERO 1, latency 17 cycles.
